// File: rtl/text_fetch_sequencer.sv
// text_fetch_sequencer: fetches character codes and glyph bytes per scan line and shifts out one pixel per clock.
// Optional blinking underline cursor is enabled by defining CURSOR_EN.
module text_fetch_sequencer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int CHAR_AW   = 13,
  parameter int FONT_AW   = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_start,
  input  logic [8:0]         line_num,
  input  logic               de,
  output logic [CHAR_AW-1:0] addrRChar,
  input  logic [7:0]         dataChar,
  output logic [FONT_AW-1:0] addrRFont,
  input  logic [7:0]         dataFont,
  output logic               pixel_o,
  output logic               pixel_de_o,
  output logic               underrun_o
`ifdef CURSOR_EN
  ,
  input  logic               frame_start,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  input  logic               cursor_on
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH_CHAR, FETCH_FONT, CAPTURE, HOLD, DONE} state_t;
  state_t state_q;
  logic [3:0]         glyph_row_q;
  logic [CHAR_AW-1:0] row_base_q;
  logic [6:0]         col_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q, pref_q;
  logic               pref_valid_q, first_q;
  logic [FONT_AW-1:0] font_q;
  logic               active, load;
  logic [7:0]         load_byte;
`ifdef CURSOR_EN
  logic [4:0] text_row_q, frame_q;
  logic [6:0] load_idx_q;
  logic       cursor_hit;
  assign cursor_hit = cursor_on & frame_q[4] & (glyph_row_q >= 4'd14) &
                      (text_row_q == cursor_row) & (load_idx_q == cursor_col);
  assign load_byte  = cursor_hit ? 8'hFF : (pref_valid_q ? pref_q : 8'h00);
`else
  assign load_byte  = pref_valid_q ? pref_q : 8'h00;
`endif
  // Loads may land in any fetch state; DONE/IDLE never load so a finished line stays blank.
  assign active    = (state_q == FETCH_CHAR) | (state_q == FETCH_FONT) | (state_q == CAPTURE) | (state_q == HOLD);
  assign load      = active & de & (first_q | (bit_q == 3'd7));
  // The font address follows the character data combinationally so the glyph arrives in CAPTURE.
  assign addrRFont = (state_q == FETCH_FONT) ? FONT_AW'({dataChar, glyph_row_q}) : font_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      glyph_row_q  <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      pref_q       <= '0;
      pref_valid_q <= 1'b0;
      first_q      <= 1'b0;
      font_q       <= '0;
      addrRChar    <= '0;
      pixel_o      <= 1'b0;
      pixel_de_o   <= 1'b0;
      underrun_o   <= 1'b0;
`ifdef CURSOR_EN
      text_row_q   <= '0;
      frame_q      <= '0;
      load_idx_q   <= '0;
`endif
    end else begin
      pixel_de_o <= de;
      font_q     <= addrRFont;
`ifdef CURSOR_EN
      if (frame_start) frame_q <= frame_q + 5'd1;
`endif
      if (line_start) begin
        glyph_row_q  <= line_num[3:0];
        row_base_q   <= CHAR_AW'(int'(line_num[8:4]) * COLS);
        col_q        <= '0;
        bit_q        <= '0;
        shift_q      <= '0;
        pref_valid_q <= 1'b0;
        pixel_o      <= 1'b0;
        first_q      <= int'(line_num[8:4]) < ROWS;
        state_q      <= int'(line_num[8:4]) < ROWS ? FETCH_CHAR : IDLE;
        if (int'(line_num[8:4]) < ROWS) addrRChar <= CHAR_AW'(BASE_ADDR + int'(line_num[8:4]) * COLS);
`ifdef CURSOR_EN
        text_row_q   <= line_num[8:4];
        load_idx_q   <= '0;
`endif
      end else begin
        if (load) begin
          pixel_o      <= load_byte[7];
          shift_q      <= {load_byte[6:0], 1'b0};
          bit_q        <= '0;
          pref_valid_q <= 1'b0;
          first_q      <= 1'b0;
          underrun_o   <= underrun_o | ~pref_valid_q;
`ifdef CURSOR_EN
          load_idx_q   <= load_idx_q + 7'd1;
`endif
        end else if (de) begin
          pixel_o <= shift_q[7];
          shift_q <= {shift_q[6:0], 1'b0};
          bit_q   <= bit_q + 3'd1;
        end else begin
          pixel_o <= 1'b0;
        end
        case (state_q)
          FETCH_CHAR: state_q <= FETCH_FONT;
          FETCH_FONT: state_q <= CAPTURE;
          CAPTURE: begin
            pref_q       <= dataFont;
            pref_valid_q <= 1'b1;
            col_q        <= col_q + 7'd1;
            state_q      <= HOLD;
          end
          HOLD: if (load) begin
            state_q <= (int'(col_q) < COLS) ? FETCH_CHAR : DONE;
            if (int'(col_q) < COLS) addrRChar <= CHAR_AW'(BASE_ADDR) + row_base_q + CHAR_AW'(col_q);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_text_fetch_sequencer.sv
// tb_text_fetch_sequencer: directed scan lines against a memory model; expected pixels are queued and checked on output.
module tb_text_fetch_sequencer;
  logic        clk = 0, rst = 1, line_start = 0, de = 0;
  logic [8:0]  line_num = 0;
  logic [12:0] addrRChar;
  logic [11:0] addrRFont;
  logic [7:0]  dataChar, dataFont;
  logic        pixel_o, pixel_de_o, underrun_o;
  logic        exp_pix_q;
  logic [7:0]  char_mem [8192];
  logic [7:0]  font_mem [4096];
  bit          exp_q [$];
  int          n_assert = 0, n_fail = 0, ones;
`ifdef CURSOR_EN
  logic        frame_start = 0, cursor_on = 0;
  logic [6:0]  cursor_col = 7'd5;
  logic [4:0]  cursor_row = 5'd1;
  int          frames = 0;
`endif

  always #5 clk = ~clk;

  text_fetch_sequencer dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_num(line_num), .de(de),
    .addrRChar(addrRChar), .dataChar(dataChar), .addrRFont(addrRFont), .dataFont(dataFont),
    .pixel_o(pixel_o), .pixel_de_o(pixel_de_o), .underrun_o(underrun_o)
`ifdef CURSOR_EN
    , .frame_start(frame_start), .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on)
`endif
  );

  always @(posedge clk) begin
    dataChar <= char_mem[addrRChar];
    dataFont <= font_mem[addrRFont];
  end

  always @(negedge clk) begin
    if (pixel_de_o && exp_q.size() > 0) begin
      exp_pix_q = exp_q.pop_front();
      n_assert++;
      assert (pixel_o === exp_pix_q) else begin
        n_fail++;
        $error("FAIL pixel obs=%0b exp=%0b line=%0d", pixel_o, exp_pix_q, line_num);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit exp_pix(input int n, input int p);
    int c;
    logic [7:0] g;
    c = p / 8;
    g = font_mem[{char_mem[(n >> 4) * 80 + c], 4'(n & 15)}];
`ifdef CURSOR_EN
    if (cursor_on && frames[4] && (n & 15) >= 14 && (n >> 4) == int'(cursor_row) && c == int'(cursor_col)) g = 8'hFF;
`endif
    return g[7 - p % 8];
  endfunction

  task automatic do_line(input int n, input int lead, input int npix, input bit ur, input bit chk_addr, input bit keep_de);
    line_start = 1; line_num = 9'(n);
    step();
    line_start = 0;
    for (int i = 1; i < lead; i++) begin
      if (chk_addr && i == 1) chk("first_addrRChar", addrRChar, (n >> 4) * 80);
      if (chk_addr && i == 2) chk("first_addrRFont", addrRFont, int'({char_mem[(n >> 4) * 80], 4'(n & 15)}));
      step();
    end
    for (int p = 0; p < npix; p++) begin
      de = 1;
      exp_q.push_back(ur ? (p < 8 ? 1'b0 : exp_pix(n, p - 8)) : exp_pix(n, p));
      step();
    end
    if (!keep_de) begin
      de = 0;
      step(); step();
    end
  endtask

`ifdef CURSOR_EN
  task automatic frames16();
    for (int i = 0; i < 16; i++) begin
      frame_start = 1; step(); frame_start = 0; frames++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8192; i++) char_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    char_mem[160] = 8'h41;
    font_mem[12'h413] = 8'hA5;
    de = 1;
    step(); step();
    chk("rst_addrRChar", addrRChar, 0);
    chk("rst_addrRFont", addrRFont, 0);
    chk("rst_pixel", pixel_o, 0);
    chk("rst_pixel_de", pixel_de_o, 0);
    chk("rst_underrun", underrun_o, 0);
    de = 0; rst = 0;
    step(); step();
    do_line(35, 6, 640, 0, 1, 0);
    chk("line35_underrun", underrun_o, 0);
    do_line(479, 4, 640, 0, 1, 0);
    chk("line479_last_addr", addrRChar, 2399);
    for (int i = 0; i < 10; i++) step();
    chk("line479_no_more_fetch", addrRChar, 2399);
    chk("line479_underrun", underrun_o, 0);
    line_start = 1; line_num = 9'd500;
    step();
    line_start = 0; ones = 0;
    for (int i = 0; i < 20; i++) begin
      de = 1; step(); ones += int'(pixel_o);
    end
    de = 0; step();
    chk("offscreen_addr_hold", addrRChar, 2399);
    chk("offscreen_pixels", ones, 0);
    chk("pre_underrun", underrun_o, 0);
    do_line(64, 1, 640, 1, 0, 0);
    chk("underrun_set", underrun_o, 1);
    do_line(16, 4, 300, 0, 0, 1);
    line_start = 1; line_num = 9'd17;
    step();
    line_start = 0;
    chk("restart_addrRChar", addrRChar, 80);
    step();
    chk("restart_font_row", int'(addrRFont[3:0]), 1);
    for (int i = 0; i < 338; i++) step();
    de = 0; step(); step();
`ifdef CURSOR_EN
    cursor_on = 1;
    frames16();
    do_line(30, 4, 640, 0, 0, 0);
    do_line(29, 4, 640, 0, 0, 0);
    frames16();
    do_line(30, 4, 640, 0, 0, 0);
`endif
    do_line(100, 4, 200, 0, 0, 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_pixel", pixel_o, 0);
    chk("midrst_pixel_de", pixel_de_o, 0);
    chk("midrst_underrun", underrun_o, 0);
    chk("midrst_addrRChar", addrRChar, 0);
    step(); step();
    rst = 0; ones = 0;
    for (int i = 0; i < 100; i++) begin
      step(); ones += int'(pixel_o);
    end
    de = 0; step();
    chk("post_rst_no_pixels", ones, 0);
    chk("post_rst_underrun", underrun_o, 0);
    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
